id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle decode stage.
- Holds the integer register file, generates immediates, selects ALU operand 2 and formats store data.
- Registers all results into an ID/EX pipeline register with valid/ready handshake, flush and write-back bypass.
- Sits between the fetch stage (upstream handshake) and the execute stage (downstream handshake); write-back port driven from WB stage.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
NREG, 32, architectural register count; 32 (RV32I) or 16 (RV32E)
AW, 5, register index width; fixed 5 (instruction field width)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept instruction this cycle
in_instr  input  32  instruction word
in_pc  input  XLEN  instruction PC
wb_en  input  1  register write enable from WB
wb_rd  input  AW  write-back destination index
wb_data  input  XLEN  write-back data
flush  input  1  kill ID/EX contents and current capture
out_valid  output  1  ID/EX register holds valid instruction
out_ready  input  1  execute stage accepts this cycle
out_pc  output  XLEN  registered PC
out_rs1_data  output  XLEN  registered rs1 value
out_op2  output  XLEN  registered ALU operand 2 (rs2 or imm)
out_imm  output  XLEN  registered sign-extended immediate
out_store_data  output  XLEN  registered formatted store data
out_rd  output  AW  registered destination index
out_regwen  output  1  registered register-write enable

Behaviour:
- Reset (rst=1 at edge): out_valid=0, all out_* data=0, out_regwen=0, all registers cleared to 0. Reset overrides wb_en and capture in same cycle.
- in_ready = !out_valid || out_ready (combinational, no dependence on in_valid).
- Capture: when in_valid && in_ready && !flush, ID/EX loads all fields, out_valid=1 next cycle. Latency 1 cycle instr->out.
- Drain: out_valid && out_ready && !(in_valid && in_ready) -> out_valid=0.
- Stall: out_valid && !out_ready -> all out_* hold stable; in_ready=0.
- flush=1: out_valid=0 next cycle regardless of in_valid/out_ready; data fields may hold; flush wins over capture.
- Register file: NREG x XLEN; write at edge when wb_en && wb_rd!=0 && wb_rd<NREG; x0 reads 0; any index >=NREG reads 0, write ignored.
- Read ports combinational from in_instr[19:15] (rs1), [24:20] (rs2).
- Immediate by opcode[6:0], sign-extended to XLEN: I (0000011, 0010011, 1100111), S (0100011), B (1100011), U (0110111, 0010111, upper 20 bits, low 12 zero), J (1101111); R-type and others -> 0.
- op2 = imm for all opcodes except 0110011 (R-type) and 1100011 (branch), where op2 = rs2.
- out_regwen = 1 for R, I, U, J opcodes; 0 for S, B, unknown; forced 0 when rd==0.
- Store data by funct3 (S-type only, else rs2 passthrough): 000 byte -> rs2[7:0] zero-extended; 001 half -> rs2[15:0] zero-extended; 010 word -> rs2[31:0] zero-extended; 011 double -> rs2 full when XLEN=64, treated as 010 when XLEN=32; 1xx -> treated as 010.

Optional Feature:
- Macro ID_WB_BYPASS_EN.
- Defined: if wb_en && wb_rd!=0 && wb_rd<NREG and wb_rd equals rs1/rs2 in the capturing cycle, the captured read value is wb_data (write-first), also feeding op2 and store data.
- Undefined: captured values are the pre-write register contents; hazard handling is left to the hazard unit.

Test Plan:
- Reset: rst=1 two cycles -> out_valid=0, out_rs1_data=0; read x5 after reset -> 0.
- Write/read: wb x3=0x1234_5678, then addi x4,x3,-1 (in_instr 0xFFF18213) -> next cycle out_rs1_data=0x12345678, out_op2=0xFFFFFFFF, out_rd=4, out_regwen=1.
- Backpressure: out_ready=0 with out_valid=1 for 3 cycles -> in_ready=0, outputs stable; out_ready=1 -> next instr captured, out_valid stays 1.
- Flush: capture cycle with flush=1 -> out_valid=0 next cycle; x0 write of 0xDEAD -> x0 still reads 0.
- Store format: x7=0xAABBCCDD, sb x7,0(x1) -> out_store_data=0x000000DD; sh -> 0x0000CCDD; sw -> 0xAABBCCDD.
- Bypass: wb x9=0x55 same cycle as add x10,x9,x9 -> out_rs1_data=out_op2=0x55 with ID_WB_BYPASS_EN, old x9 value without.

Source files
------------

// File: rtl/id_stage_pipe.sv
// Pipelined decode stage: register file, immediate generation, operand-2 select,
// store-data formatting and a valid/ready ID/EX register. Optional macro: ID_WB_BYPASS_EN.
module id_stage_pipe #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_op2,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_store_data,
  output logic [AW-1:0]   out_rd,
  output logic            out_regwen
);

  localparam int IW = $clog2(NREG);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  function automatic logic signed [XLEN-1:0] imm_gen(input logic [31:0] ins);
    logic signed [31:0] imm32;
    case (ins[6:0])
      OP_LOAD, OP_IMM, OP_JALR: imm32 = {{20{ins[31]}}, ins[31:20]};
      OP_STORE:                 imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      OP_BRANCH:                imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         imm32 = {ins[31:12], 12'b0};
      OP_JAL:                   imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default:                  imm32 = '0;
    endcase
    return XLEN'(imm32);
  endfunction

  function automatic logic [XLEN-1:0] store_fmt(input logic [2:0] f3, input logic [XLEN-1:0] rs2);
    case (f3)
      3'b000:  return XLEN'(rs2[7:0]);
      3'b001:  return XLEN'(rs2[15:0]);
      3'b011:  return (XLEN == 64) ? rs2 : XLEN'(rs2[31:0]);
      default: return XLEN'(rs2[31:0]);
    endcase
  endfunction

  function automatic logic writes_rd(input logic [6:0] op);
    case (op)
      OP_REG, OP_LOAD, OP_IMM, OP_JALR, OP_LUI, OP_AUIPC, OP_JAL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic idx_valid(input logic [AW-1:0] idx);
    return (idx != '0) && (32'(idx) < NREG);
  endfunction

  logic [XLEN-1:0] regs [NREG];
  logic            wb_hit;

  assign wb_hit = wb_en && idx_valid(wb_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_hit) begin
      regs[wb_rd[IW-1:0]] <= wb_data;
    end
  end

  // ---- p0: combinational decode of the instruction at the stage input ----
  logic [AW-1:0]   rs1_idx_p0, rs2_idx_p0, rd_p0;
  logic [6:0]      opcode_p0;
  logic [XLEN-1:0] rs1_rf_p0, rs2_rf_p0, rs1_data_p0, rs2_data_p0;
  logic [XLEN-1:0] imm_p0, op2_p0, store_p0;
  logic            regwen_p0;

  assign rs1_idx_p0 = in_instr[19:15];
  assign rs2_idx_p0 = in_instr[24:20];
  assign rd_p0      = in_instr[11:7];
  assign opcode_p0  = in_instr[6:0];

  assign rs1_rf_p0 = idx_valid(rs1_idx_p0) ? regs[rs1_idx_p0[IW-1:0]] : '0;
  assign rs2_rf_p0 = idx_valid(rs2_idx_p0) ? regs[rs2_idx_p0[IW-1:0]] : '0;

`ifdef ID_WB_BYPASS_EN
  assign rs1_data_p0 = (wb_hit && wb_rd == rs1_idx_p0) ? wb_data : rs1_rf_p0;
  assign rs2_data_p0 = (wb_hit && wb_rd == rs2_idx_p0) ? wb_data : rs2_rf_p0;
`else
  assign rs1_data_p0 = rs1_rf_p0;
  assign rs2_data_p0 = rs2_rf_p0;
`endif

  assign imm_p0    = imm_gen(in_instr);
  assign op2_p0    = (opcode_p0 == OP_REG || opcode_p0 == OP_BRANCH) ? rs2_data_p0 : imm_p0;
  assign store_p0  = (opcode_p0 == OP_STORE) ? store_fmt(in_instr[14:12], rs2_data_p0) : rs2_data_p0;
  assign regwen_p0 = writes_rd(opcode_p0) && (rd_p0 != '0);

  // ---- p1: ID/EX register with valid/ready handshake ----
  logic            vld_p1;
  logic [XLEN-1:0] pc_p1, rs1_data_p1, op2_p1, imm_p1, store_p1;
  logic [AW-1:0]   rd_p1;
  logic            regwen_p1;
  logic            capture;

  assign in_ready = !vld_p1 || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      pc_p1       <= '0;
      rs1_data_p1 <= '0;
      op2_p1      <= '0;
      imm_p1      <= '0;
      store_p1    <= '0;
      rd_p1       <= '0;
      regwen_p1   <= 1'b0;
    end else begin
      if (flush)             vld_p1 <= 1'b0;
      else if (capture)      vld_p1 <= 1'b1;
      else if (out_ready)    vld_p1 <= 1'b0;
      if (capture) begin
        pc_p1       <= in_pc;
        rs1_data_p1 <= rs1_data_p0;
        op2_p1      <= op2_p0;
        imm_p1      <= imm_p0;
        store_p1    <= store_p0;
        rd_p1       <= rd_p0;
        regwen_p1   <= regwen_p0;
      end
    end
  end

  assign out_valid      = vld_p1;
  assign out_pc         = pc_p1;
  assign out_rs1_data   = rs1_data_p1;
  assign out_op2        = op2_p1;
  assign out_imm        = imm_p1;
  assign out_store_data = store_p1;
  assign out_rd         = rd_p1;
  assign out_regwen     = regwen_p1;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed-vector bench for id_stage_pipe (default XLEN=32, NREG=32).
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_rs1_data;
  logic [31:0] out_op2;
  logic [31:0] out_imm;
  logic [31:0] out_store_data;
  logic [4:0]  out_rd;
  logic        out_regwen;

  int checks   = 0;
  int failures = 0;

  id_stage_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1_data(out_rs1_data), .out_op2(out_op2),
    .out_imm(out_imm), .out_store_data(out_store_data), .out_rd(out_rd),
    .out_regwen(out_regwen)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] byp_exp;

  initial begin
`ifdef ID_WB_BYPASS_EN
    byp_exp = 32'h55;
`else
    byp_exp = 32'h11;
`endif
    // Reset with a concurrent write and capture attempt: reset must win.
    rst = 1; flush = 0; out_ready = 1;
    wb_en = 1; wb_rd = 5'd5; wb_data = 32'hBEEF;
    in_valid = 1; in_instr = 32'h00028313; in_pc = 32'h100;
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_rs1", out_rs1_data, 0);
    chk("rst_regwen", out_regwen, 0);
    chk("rst_in_ready", in_ready, 1);

    // addi x6,x5,0: x5 must read 0 after reset
    rst = 0; wb_en = 0;
    tick();
    chk("x5_valid", out_valid, 1);
    chk("x5_rs1", out_rs1_data, 0);
    chk("x5_rd", out_rd, 6);
    chk("x5_pc", out_pc, 32'h100);

    // Write x3, check drain
    in_valid = 0; wb_en = 1; wb_rd = 5'd3; wb_data = 32'h12345678;
    tick();
    chk("drain_valid", out_valid, 0);

    // addi x4,x3,-1
    wb_en = 0; in_valid = 1; in_instr = 32'hFFF18213; in_pc = 32'h104;
    tick();
    chk("addi_valid", out_valid, 1);
    chk("addi_rs1", out_rs1_data, 32'h12345678);
    chk("addi_op2", out_op2, 32'hFFFFFFFF);
    chk("addi_imm", out_imm, 32'hFFFFFFFF);
    chk("addi_rd", out_rd, 4);
    chk("addi_regwen", out_regwen, 1);

    // Backpressure: lui x2,0x12345 waits while downstream stalls
    out_ready = 0; in_instr = 32'h12345137; in_pc = 32'h200;
    #1;
    chk("stall_in_ready0", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", out_valid, 1);
      chk("stall_rs1", out_rs1_data, 32'h12345678);
      chk("stall_rd", out_rd, 4);
      chk("stall_pc", out_pc, 32'h104);
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready = 1;
    #1;
    chk("unstall_in_ready", in_ready, 1);
    tick();
    chk("lui_valid", out_valid, 1);
    chk("lui_imm", out_imm, 32'h12345000);
    chk("lui_op2", out_op2, 32'h12345000);
    chk("lui_rd", out_rd, 2);
    chk("lui_pc", out_pc, 32'h200);
    chk("lui_regwen", out_regwen, 1);

    // Flush beats capture
    flush = 1; in_instr = 32'h00500093; in_pc = 32'h300;
    tick();
    chk("flush_valid", out_valid, 0);
    flush = 0; in_valid = 0;

    // x0 write ignored, then addi x1,x0,5
    wb_en = 1; wb_rd = 5'd0; wb_data = 32'hDEAD;
    tick();
    wb_en = 0; in_valid = 1; in_instr = 32'h00500093;
    tick();
    chk("x0_rs1", out_rs1_data, 0);
    chk("x0_op2", out_op2, 5);
    chk("x0_rd", out_rd, 1);

    // Store formatting from x7
    in_valid = 0; wb_en = 1; wb_rd = 5'd7; wb_data = 32'hAABBCCDD;
    tick();
    wb_en = 0; in_valid = 1; in_instr = 32'h00708023;
    tick();
    chk("sb_data", out_store_data, 32'h000000DD);
    chk("sb_regwen", out_regwen, 0);
    chk("sb_op2", out_op2, 0);
    in_instr = 32'h00709023;
    tick();
    chk("sh_data", out_store_data, 32'h0000CCDD);
    in_instr = 32'h0070A023;
    tick();
    chk("sw_data", out_store_data, 32'hAABBCCDD);
    in_instr = 32'h0070B023;
    tick();
    chk("sd_data", out_store_data, 32'hAABBCCDD);

    // beq x3,x7,-4: op2 is rs2, no register write
    in_instr = 32'hFE718EE3;
    tick();
    chk("beq_imm", out_imm, 32'hFFFFFFFC);
    chk("beq_op2", out_op2, 32'hAABBCCDD);
    chk("beq_rs1", out_rs1_data, 32'h12345678);
    chk("beq_regwen", out_regwen, 0);
    chk("beq_store", out_store_data, 32'hAABBCCDD);

    // addi x0,x3,1: regwen forced off for rd=0
    in_instr = 32'h00118013;
    tick();
    chk("rd0_regwen", out_regwen, 0);
    chk("rd0_op2", out_op2, 1);

    // Same-cycle write-back and read of x9
    in_valid = 0; wb_en = 1; wb_rd = 5'd9; wb_data = 32'h11;
    tick();
    wb_data = 32'h55; in_valid = 1; in_instr = 32'h00948533;
    tick();
    chk("byp_rs1", out_rs1_data, byp_exp);
    chk("byp_op2", out_op2, byp_exp);
    chk("byp_rd", out_rd, 10);
    wb_en = 0;
    tick();
    chk("after_byp_rs1", out_rs1_data, 32'h55);

    in_valid = 0;
    tick();
    chk("final_drain", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
